// File: rtl/lebug_pkg.sv
// ============================================================================
// lebug_pkg : shared defaults and helpers for the debug pipeline front end.
// Rev 1.0
// ============================================================================
`default_nettype none

package lebug_pkg;

   localparam int DEF_N          = 8;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_IB_DEPTH   = 4;

   // Address bits plus one wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_dual_port.sv
// ============================================================================
// ram_dual_port : simple dual-port RAM, write on port a, registered read on b.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_dual_port #(
   parameter int WIDTH    = 8,
   parameter int NUMWORDS = 4,
   parameter int ADDR_W   = $clog2(NUMWORDS)
) (
   input  logic              clk,
   input  logic              i_clken,
   input  logic              i_wren_a,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [WIDTH-1:0]  i_data_a,
   input  logic [ADDR_W-1:0] i_addr_b,
   output logic [WIDTH-1:0]  o_q_b
);

   logic [WIDTH-1:0] r_mem [NUMWORDS];
   logic [WIDTH-1:0] r_q;

   // Read-during-write to the same address returns the old word.
   always_ff @(posedge clk) begin
      if (i_clken) begin
         if (i_wren_a) begin
            r_mem[i_addr_a] <= i_data_a;
         end
         r_q <= r_mem[i_addr_b];
      end
   end

   assign o_q_b = r_q;

endmodule

`default_nettype wire

// File: rtl/vector_fifo.sv
// ============================================================================
// vector_fifo : circular FIFO of N-lane vectors with eof tag, status flags and
//               sticky overflow.
// Rev 1.0
// ============================================================================
`default_nettype none

module vector_fifo
   import lebug_pkg::*;
#(
   parameter int N            = DEF_N,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int IB_DEPTH     = DEF_IB_DEPTH,
   parameter int AF_THRESHOLD = IB_DEPTH - 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enqueue,
   input  logic                             eof_in,
   input  logic [DATA_WIDTH-1:0]            vector_in [N],
   input  logic                             dequeue,
   output logic                             valid_out,
   output logic                             eof_out,
   output logic [DATA_WIDTH-1:0]            vector_out [N],
   output logic                             full,
   output logic                             almost_full,
   output logic                             empty,
   output logic [ptr_width(IB_DEPTH)-1:0]   occupancy,
   output logic                             overflow
);

   localparam int c_PTR_W  = ptr_width(IB_DEPTH);
   localparam int c_ADDR_W = c_PTR_W - 1;
   localparam int c_WORD_W = N * DATA_WIDTH + 1;
   localparam logic [c_PTR_W-1:0] c_AF = c_PTR_W'(AF_THRESHOLD);

   if ((IB_DEPTH < 2) || ((IB_DEPTH & (IB_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("vector_fifo: IB_DEPTH must be a power of two and at least 2");
   end
   if ((AF_THRESHOLD < 1) || (AF_THRESHOLD > IB_DEPTH)) begin : g_bad_af
      $error("vector_fifo: AF_THRESHOLD must lie in 1..IB_DEPTH");
   end

   logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr, r_occ;
   logic                r_full, r_af, r_empty, r_ovf, r_valid;
   logic [c_WORD_W-1:0] r_hold;

   logic                w_rd_acc, w_wr_acc;
   logic [c_PTR_W-1:0]  w_wr_nxt, w_rd_nxt, w_occ_nxt;
   logic [c_WORD_W-1:0] w_wdata, w_q, w_rdata;

   assign w_rd_acc = dequeue && !r_empty;
   assign w_wr_acc = enqueue && (!r_full || w_rd_acc);
   assign w_wr_nxt = r_wr_ptr + c_PTR_W'(w_wr_acc);
   assign w_rd_nxt = r_rd_ptr + c_PTR_W'(w_rd_acc);

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_wr_acc && !w_rd_acc) begin
         w_occ_nxt = r_occ + 1'b1;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_occ_nxt = r_occ - 1'b1;
      end
   end

   always_comb begin
      w_wdata = '0;
      w_wdata[c_WORD_W-1] = eof_in;
      for (int l = 0; l < N; l++) begin
         w_wdata[l*DATA_WIDTH +: DATA_WIDTH] = vector_in[l];
      end
   end

   ram_dual_port #(
      .WIDTH    (c_WORD_W),
      .NUMWORDS (IB_DEPTH),
      .ADDR_W   (c_ADDR_W)
   ) u_ram (
      .clk      (clk),
      .i_clken  (1'b1),
      .i_wren_a (w_wr_acc),
      .i_addr_a (r_wr_ptr[c_ADDR_W-1:0]),
      .i_data_a (w_wdata),
      .i_addr_b (r_rd_ptr[c_ADDR_W-1:0]),
      .o_q_b    (w_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_full   <= 1'b0;
         r_af     <= 1'b0;
         r_empty  <= 1'b1;
         r_ovf    <= 1'b0;
         r_valid  <= 1'b0;
         r_hold   <= '0;
      end else begin
         r_wr_ptr <= w_wr_nxt;
         r_rd_ptr <= w_rd_nxt;
         r_occ    <= w_occ_nxt;
         r_empty  <= (w_wr_nxt == w_rd_nxt);
         r_full   <= (w_wr_nxt[c_ADDR_W-1:0] == w_rd_nxt[c_ADDR_W-1:0]) &&
                     (w_wr_nxt[c_ADDR_W] != w_rd_nxt[c_ADDR_W]);
         r_af     <= (w_occ_nxt >= c_AF);
         r_valid  <= w_rd_acc;
         if (enqueue && !w_wr_acc) begin
            r_ovf <= 1'b1;
         end
         if (r_valid) begin
            r_hold <= w_q;
         end
      end
   end

   // RAM output is live only during the pop cycle; otherwise show the last pop.
   assign w_rdata = r_valid ? w_q : r_hold;

   always_comb begin
      for (int l = 0; l < N; l++) begin
         vector_out[l] = w_rdata[l*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign eof_out     = w_rdata[c_WORD_W-1];
   assign valid_out   = r_valid;
   assign full        = r_full;
   assign almost_full = r_af;
   assign empty       = r_empty;
   assign occupancy   = r_occ;
   assign overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vector_fifo.sv
// ============================================================================
// tb_vector_fifo : self-checking bench for vector_fifo (N=4, DW=8, depth 4).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_fifo;

   localparam int c_N  = 4;
   localparam int c_DW = 8;
   localparam int c_D  = 4;
   localparam int c_AF = 3;

   logic          clk, rst, enqueue, eof_in, dequeue;
   logic [c_DW-1:0] vector_in  [c_N];
   logic [c_DW-1:0] vector_out [c_N];
   logic          valid_out, eof_out, full, almost_full, empty, overflow;
   logic [2:0]    occupancy;

   vector_fifo #(
      .N            (c_N),
      .DATA_WIDTH   (c_DW),
      .IB_DEPTH     (c_D),
      .AF_THRESHOLD (c_AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enqueue     (enqueue),
      .eof_in      (eof_in),
      .vector_in   (vector_in),
      .dequeue     (dequeue),
      .valid_out   (valid_out),
      .eof_out     (eof_out),
      .vector_out  (vector_out),
      .full        (full),
      .almost_full (almost_full),
      .empty       (empty),
      .occupancy   (occupancy),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        enq;
      logic        eof;
      logic [31:0] vec;
      logic        deq;
      logic [2:0]  occ;
      logic        af;
      logic        full;
      logic        empty;
      logic        ovf;
   } vec_rec_t;

   vec_rec_t      tbl [11];
   logic [32:0]   mq [$];
   logic [32:0]   sb [$];
   logic          m_ovf;
   int            checks, errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      logic [31:0] v;
      for (int l = 0; l < c_N; l++) v[8*l +: 8] = vector_out[l];
      return v;
   endfunction

   task automatic drive(input logic e, input logic ef, input logic [31:0] v, input logic d);
      enqueue = e;
      eof_in  = ef;
      dequeue = d;
      for (int l = 0; l < c_N; l++) vector_in[l] = v[8*l +: 8];
   endtask

   // Update the reference queue for one cycle; returns whether a pop happens.
   task automatic model(input logic e, input logic ef, input logic [31:0] v,
                        input logic d, output logic rd);
      logic wr;
      rd = d && (mq.size() > 0);
      wr = e && ((mq.size() < c_D) || rd);
      if (e && !wr) m_ovf = 1'b1;
      if (rd) sb.push_back(mq.pop_front());
      if (wr) mq.push_back({ef, v});
   endtask

   // Called at a negedge; checks outputs at the following negedge.
   task automatic step(input logic e, input logic ef, input logic [31:0] v, input logic d);
      logic        rd;
      logic [32:0] w;
      drive(e, ef, v, d);
      model(e, ef, v, d, rd);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      chk("valid_out", valid_out, rd);
      if (rd) begin
         w = sb.pop_front();
         if (valid_out) begin
            chk("vector_out", out_vec(), w[31:0]);
            chk("eof_out", eof_out, w[32]);
         end
      end
      chk("occupancy", occupancy, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == c_D);
      chk("almost_full", almost_full, mq.size() >= c_AF);
      chk("overflow", overflow, m_ovf);
   endtask

   initial begin
      logic        rd;
      logic [31:0] rv;
      checks = 0;
      errors = 0;
      m_ovf  = 1'b0;
      rst    = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 1'b0);

      tbl[0]  = '{1'b1, 1'b0, 32'h04030201, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h08070605, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 32'h0C0B0A09, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 32'h100F0E0D, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 32'h55555555, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 32'hAAAAAAAA, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};

      #1;
      chk("rst_empty", empty, 1'b1);
      chk("rst_occ", occupancy, 3'd0);
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_vec", out_vec(), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Fill, pass-through, overflow, drain, dequeue on empty.
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].enq, tbl[i].eof, tbl[i].vec, tbl[i].deq);
         chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
         chk($sformatf("tbl%0d_af", i), almost_full, tbl[i].af);
         chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
         chk($sformatf("tbl%0d_empty", i), empty, tbl[i].empty);
         chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
      end
      chk("hold_vec", out_vec(), 32'h55555555);

      // Enqueue and dequeue together on an empty FIFO: no bypass.
      step(1'b1, 1'b1, 32'h07070707, 1'b1);
      chk("corner_valid", valid_out, 1'b0);
      chk("corner_occ", occupancy, 3'd1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk("corner_pop_valid", valid_out, 1'b1);
      chk("corner_pop_eof", eof_out, 1'b1);
      chk("corner_pop_vec", out_vec(), 32'h07070707);

      // Interleaved traffic so both pointers wrap more than twice.
      for (int i = 0; i < 10; i++) begin
         rv = $urandom;
         step(1'b1, rv[0], rv, 1'b1);
      end
      for (int i = 0; i < 3; i++) begin
         rv = $urandom;
         step(1'b1, rv[1], rv, 1'b0);
      end

      // Reset asserted between edges while a pop is in flight.
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      model(1'b0, 1'b0, 32'h0, 1'b1, rd);
      @(posedge clk);
      #1;
      chk("inflight_valid", valid_out, rd);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", valid_out, 1'b0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_occ", occupancy, 3'd0);
      chk("mid_rst_full", full, 1'b0);
      chk("mid_rst_af", almost_full, 1'b0);
      chk("mid_rst_ovf", overflow, 1'b0);
      chk("mid_rst_eof", eof_out, 1'b0);
      chk("mid_rst_vec", out_vec(), 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      mq.delete();
      sb.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("post_rst_valid", valid_out, 1'b0);
      step(1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
